// File: rtl/apb_gpio_v2.sv
// APB GPIO controller: parametrised pin count, sticky W1C interrupt status,
// atomic OUT set/clear/toggle and per-pin input debounce. Zero wait states.
`timescale 1ns/1ps
module apb_gpio_v2 #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_GPIO       = 32,
  parameter int DEBOUNCE_W     = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic [NUM_GPIO-1:0]       gpio_dir,
  output logic [2*NUM_GPIO-1:0]     gpio_mux,
  output logic                      interrupt
);

  logic [3:0]          idx;
  logic                access;
  logic                wr;
  logic [NUM_GPIO-1:0] wdata;
  logic                unused;

  logic [NUM_GPIO-1:0] fun0, fun1, dir, out_r, inten, type0, type1, status, dben;
  logic [DEBOUNCE_W-1:0] dbcnt;

  logic [NUM_GPIO-1:0] sync0, sync1, filt, prev;
  logic [NUM_GPIO-1:0][DEBOUNCE_W-1:0] cnt;
  logic [NUM_GPIO-1:0] evt, w1c;
  logic [31:0]         rd;

  assign idx    = PADDR[5:2];
  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign wdata  = PWDATA[NUM_GPIO-1:0];
  assign unused = ^{PADDR, PWDATA};

  assign PREADY    = 1'b1;
  assign PSLVERR   = access & (idx[3] & idx[2] & idx[1]);
  assign gpio_out  = out_r;
  assign gpio_dir  = dir;
  assign gpio_mux  = {fun1, fun0};
  assign interrupt = |status;

  // Event select by {INTTYPE1, INTTYPE0}: level high, level low, rise, fall.
  assign evt = inten & ((~type1 & ~type0 & filt) |
                        (~type1 &  type0 & ~filt) |
                        ( type1 & ~type0 & filt & ~prev) |
                        ( type1 &  type0 & ~filt & prev));
  assign w1c = (wr && idx == 4'd8) ? wdata : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fun0   <= '0;
      fun1   <= '0;
      dir    <= '0;
      out_r  <= '0;
      inten  <= '0;
      type0  <= '0;
      type1  <= '0;
      status <= '0;
      dben   <= '0;
      dbcnt  <= '0;
    end else begin
      if (wr) begin
        case (idx)
          4'd0:    fun0  <= wdata;
          4'd1:    fun1  <= wdata;
          4'd2:    dir   <= wdata;
          4'd4:    out_r <= wdata;
          4'd5:    inten <= wdata;
          4'd6:    type0 <= wdata;
          4'd7:    type1 <= wdata;
          4'd9:    out_r <= out_r | wdata;
          4'd10:   out_r <= out_r & ~wdata;
          4'd11:   out_r <= out_r ^ wdata;
          4'd12:   dben  <= wdata;
          4'd13:   dbcnt <= PWDATA[DEBOUNCE_W-1:0];
          default: ;
        endcase
      end
      // A new event in the same cycle as a W1C keeps the bit set.
      status <= (status & ~w1c) | evt;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync0 <= '0;
      sync1 <= '0;
      filt  <= '0;
      prev  <= '0;
      cnt   <= '0;
    end else begin
      sync0 <= gpio_in;
      sync1 <= sync0;
      prev  <= filt;
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (!dben[i]) begin
          filt[i] <= sync1[i];
          cnt[i]  <= '0;
        end else if (sync1[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == dbcnt) begin
          filt[i] <= sync1[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    case (idx)
      4'd0:    rd[NUM_GPIO-1:0]   = fun0;
      4'd1:    rd[NUM_GPIO-1:0]   = fun1;
      4'd2:    rd[NUM_GPIO-1:0]   = dir;
      4'd3:    rd[NUM_GPIO-1:0]   = filt;
      4'd4:    rd[NUM_GPIO-1:0]   = out_r;
      4'd5:    rd[NUM_GPIO-1:0]   = inten;
      4'd6:    rd[NUM_GPIO-1:0]   = type0;
      4'd7:    rd[NUM_GPIO-1:0]   = type1;
      4'd8:    rd[NUM_GPIO-1:0]   = status;
      4'd12:   rd[NUM_GPIO-1:0]   = dben;
      4'd13:   rd[DEBOUNCE_W-1:0] = dbcnt;
      default: rd = '0;
    endcase
  end

  assign PRDATA = rd;

endmodule

// File: tb/tb_apb_gpio_v2.sv
// Directed bench for apb_gpio_v2: a 32-pin instance and an 8-pin instance on one APB bus.
`timescale 1ns/1ps
module tb_apb_gpio_v2;

  logic        HCLK, HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PSEL8, PENABLE;
  logic [31:0] PRDATA, PRDATA8;
  logic        PREADY, PREADY8, PSLVERR, PSLVERR8;
  logic [31:0] gpio_in, gpio_out, gpio_dir;
  logic [63:0] gpio_mux;
  logic        interrupt;
  logic [7:0]  gpio_in8, gpio_out8, gpio_dir8;
  logic [15:0] gpio_mux8;
  logic        interrupt8;

  int errors = 0;
  int checks = 0;
  bit sel8   = 0;

  apb_gpio_v2 #(.APB_ADDR_WIDTH(12), .NUM_GPIO(32), .DEBOUNCE_W(8)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_dir(gpio_dir), .gpio_mux(gpio_mux),
    .interrupt(interrupt));

  apb_gpio_v2 #(.APB_ADDR_WIDTH(12), .NUM_GPIO(8), .DEBOUNCE_W(8)) u_dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL8), .PENABLE(PENABLE), .PRDATA(PRDATA8), .PREADY(PREADY8), .PSLVERR(PSLVERR8),
    .gpio_in(gpio_in8), .gpio_out(gpio_out8), .gpio_dir(gpio_dir8), .gpio_mux(gpio_mux8),
    .interrupt(interrupt8));

  initial HCLK = 0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic drive_sel(input logic v);
    PSEL  = sel8 ? 1'b0 : v;
    PSEL8 = sel8 ? v : 1'b0;
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge HCLK);
    PADDR = a; PWDATA = d; PWRITE = 1; PENABLE = 0; drive_sel(1);
    @(negedge HCLK);
    PENABLE = 1;
    @(negedge HCLK);
    PENABLE = 0; PWRITE = 0; drive_sel(0);
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge HCLK);
    PADDR = a; PWRITE = 0; PENABLE = 0; drive_sel(1);
    @(negedge HCLK);
    PENABLE = 1;
    #1;
    d = sel8 ? PRDATA8 : PRDATA;
    e = sel8 ? PSLVERR8 : PSLVERR;
    @(negedge HCLK);
    PENABLE = 0; drive_sel(0);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0 || interrupt !== 1'b0 || gpio_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: pready=%b pslverr=%b irq=%b out=%h, want 1 0 0 0",
               PREADY, PSLVERR, interrupt, gpio_out);
    end
    for (int i = 0; i < 14; i++) begin
      apb_read(12'(i * 4), d, e);
      checks++;
      if (d !== 32'h0 || e !== 1'b0) begin
        errors++;
        $display("FAIL reset_read_idx%0d: data=%h err=%b, want 0 0", i, d, e);
      end
    end
    for (int i = 14; i < 16; i++) begin
      apb_read(12'(i * 4), d, e);
      checks++;
      if (d !== 32'h0 || e !== 1'b1) begin
        errors++;
        $display("FAIL unmapped_idx%0d: data=%h err=%b, want 0 1", i, d, e);
      end
    end
  endtask

  task automatic test_out_atomic();
    logic [31:0] d; logic e;
    apb_write(12'h010, 32'h0000_00F0);
    apb_write(12'h024, 32'h0000_0003);
    apb_write(12'h028, 32'h0000_0030);
    apb_write(12'h02C, 32'h0000_0101);
    apb_read(12'h010, d, e);
    checks++;
    if (d !== 32'h0000_01C2 || gpio_out !== 32'h0000_01C2) begin
      errors++;
      $display("FAIL out_atomic: OUT=%h gpio_out=%h, want 000001c2", d, gpio_out);
    end
    for (int i = 9; i < 12; i++) begin
      apb_read(12'(i * 4), d, e);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL wo_read_idx%0d: data=%h, want 0", i, d);
      end
    end
  endtask

  task automatic test_rising_edge();
    logic [31:0] d; logic e;
    apb_write(12'h018, 32'h0);
    apb_write(12'h01C, 32'h20);
    apb_write(12'h014, 32'h20);
    @(negedge HCLK); gpio_in[5] = 1'b1;
    repeat (3) @(negedge HCLK);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL rise_early: irq=%b at N+2, want 0", interrupt);
    end
    @(negedge HCLK);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL rise_n3: irq=%b at N+3, want 1", interrupt);
    end
    for (int k = 0; k < 2; k++) begin
      apb_read(12'h020, d, e);
      checks++;
      if (d !== 32'h20) begin
        errors++; $display("FAIL rise_status_read%0d: status=%h, want 00000020", k, d);
      end
    end
    apb_write(12'h020, 32'h20);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL rise_w1c: irq=%b, want 0", interrupt);
    end
    apb_read(12'h020, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL rise_status_clr: status=%h, want 0", d);
    end
    gpio_in[5] = 1'b0;
  endtask

  task automatic test_level_set_wins();
    logic [31:0] d; logic e;
    apb_write(12'h014, 32'h1);
    @(negedge HCLK); gpio_in[0] = 1'b1;
    repeat (4) @(negedge HCLK);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL level_set: irq=%b, want 1", interrupt);
    end
    PADDR = 12'h020; PWDATA = 32'h1; PWRITE = 1; PENABLE = 0; PSEL = 1;
    @(negedge HCLK); PENABLE = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge HCLK);
      checks++;
      if (interrupt !== 1'b1) begin
        errors++; $display("FAIL set_wins_cyc%0d: irq=%b, want 1", k, interrupt);
      end
    end
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    gpio_in[0] = 1'b0;
    repeat (5) @(negedge HCLK);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL level_sticky: irq=%b, want 1", interrupt);
    end
    apb_write(12'h020, 32'h1);
    apb_read(12'h020, d, e);
    checks++;
    if (interrupt !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL level_clear: irq=%b status=%h, want 0 0", interrupt, d);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d; logic e;
    bit seen;
    apb_write(12'h01C, 32'h04);
    apb_write(12'h014, 32'h04);
    apb_write(12'h030, 32'h04);
    apb_write(12'h034, 32'h04);
    @(negedge HCLK);
    PADDR = 12'h00C; PWRITE = 0; PENABLE = 0; PSEL = 1;
    @(negedge HCLK); PENABLE = 1;
    @(negedge HCLK); gpio_in[2] = 1'b1;
    repeat (3) @(negedge HCLK);
    gpio_in[2] = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge HCLK);
      if (PRDATA[2] !== 1'b0 || interrupt !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL glitch_reject: padin2 or irq went high on 3-cycle pulse, want 0");
    end
    gpio_in[2] = 1'b1;
    repeat (6) @(negedge HCLK);
    checks++;
    if (PRDATA[2] !== 1'b0) begin
      errors++; $display("FAIL db_early: padin2=%b at N+5, want 0", PRDATA[2]);
    end
    @(negedge HCLK);
    checks++;
    if (PRDATA[2] !== 1'b1) begin
      errors++; $display("FAIL db_n6: padin2=%b at N+6, want 1", PRDATA[2]);
    end
    repeat (4) @(negedge HCLK);
    gpio_in[2] = 1'b0;
    PSEL = 0; PENABLE = 0;
    apb_read(12'h020, d, e);
    checks++;
    if (d !== 32'h4 || interrupt !== 1'b1) begin
      errors++; $display("FAIL db_status: status=%h irq=%b, want 00000004 1", d, interrupt);
    end
    apb_write(12'h020, 32'h4);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL db_clear: irq=%b, want 0", interrupt);
    end
  endtask

  task automatic test_narrow();
    logic [31:0] d; logic e;
    sel8 = 1;
    apb_write(12'h008, 32'hFFFF_FFFF);
    apb_read(12'h008, d, e);
    checks++;
    if (d !== 32'h0000_00FF || gpio_dir8 !== 8'hFF) begin
      errors++; $display("FAIL narrow_dir: DIR=%h gpio_dir=%h, want 000000ff ff", d, gpio_dir8);
    end
    apb_write(12'h004, 32'hFFFF_FFFF);
    checks++;
    if (gpio_mux8 !== 16'hFF00) begin
      errors++; $display("FAIL narrow_mux: gpio_mux=%h, want ff00", gpio_mux8);
    end
    sel8 = 0;
  endtask

  task automatic test_async_reset();
    apb_write(12'h014, 32'h1);
    @(negedge HCLK); gpio_in[0] = 1'b1;
    repeat (5) @(negedge HCLK);
    PADDR = 12'h010; PWRITE = 0; PENABLE = 1; PSEL = 1;
    #2 HRESETn = 0;
    #1;
    checks++;
    if (gpio_out !== 32'h0 || interrupt !== 1'b0 || PRDATA !== 32'h0 || gpio_dir8 !== 8'h0) begin
      errors++;
      $display("FAIL async_reset: out=%h irq=%b prdata=%h dir8=%h, want all 0",
               gpio_out, interrupt, PRDATA, gpio_dir8);
    end
    PSEL = 0; PENABLE = 0; gpio_in = '0;
  endtask

  initial begin
    HRESETn = 0; PADDR = '0; PWDATA = '0; PWRITE = 0; PSEL = 0; PSEL8 = 0; PENABLE = 0;
    gpio_in = '0; gpio_in8 = '0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1;
    test_reset();
    test_out_atomic();
    test_rising_edge();
    test_level_set_wins();
    test_debounce();
    test_narrow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_gpio_v2.md
# apb_gpio_v2

Parametrised APB GPIO controller, the successor GPIO block on the peripheral APB bus. Adds:
- a configurable pin count;
- per-pin sticky interrupt status with write-1-to-clear;
- atomic set/clear/toggle of the output register;
- per-pin programmable input debounce.

Zero-wait-state APB slave. One combined interrupt line to the event/interrupt controller.

## Interface
- APB_ADDR_WIDTH, 12, APB address width (4 KB slave window).
- NUM_GPIO, 32, number of pins, legal range 1..32.
- DEBOUNCE_W, 8, width of the debounce threshold and of each per-pin counter.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  APB_ADDR_WIDTH  APB address; register index is PADDR[5:2].
- PWDATA  in  32  write data.
- PWRITE  in  1  1 = write.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PRDATA  out  32  read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  error on unmapped index.
- gpio_in  in  NUM_GPIO  pad inputs, asynchronous to HCLK.
- gpio_out  out  NUM_GPIO  output register.
- gpio_dir  out  NUM_GPIO  direction, 1 = output.
- gpio_mux  out  2*NUM_GPIO  {FUN1, FUN0} pad function select.
- interrupt  out  1  OR of INTSTATUS.

## Operation
Register map. Index = PADDR[5:2]; offset in brackets. Only bits [NUM_GPIO-1:0] are implemented unless stated; unimplemented bits read 0 and ignore writes.
- 0 [0x00] FUN0, RW.
- 1 [0x04] FUN1, RW.
- 2 [0x08] DIR, RW.
- 3 [0x0C] PADIN, RO: filtered input.
- 4 [0x10] OUT, RW.
- 5 [0x14] INTEN, RW.
- 6 [0x18] INTTYPE0, RW.
- 7 [0x1C] INTTYPE1, RW.
- 8 [0x20] INTSTATUS, RW1C.
- 9 [0x24] OUTSET, WO: OUT |= PWDATA.
- 10 [0x28] OUTCLR, WO: OUT &= ~PWDATA.
- 11 [0x2C] OUTTGL, WO: OUT ^= PWDATA.
- 12 [0x30] DBEN, RW: per-pin debounce enable.
- 13 [0x34] DBCNT, RW: bits [DEBOUNCE_W-1:0] only.

APB access:
- Access = PSEL & PENABLE. Writes commit on that HCLK edge.
- PRDATA is combinational from the index and is meaningful when PSEL=1.
- Reading a WO register returns 0. Writing PADIN is ignored, with no error.
- Index 14..15: PSLVERR=1 during the access phase, write ignored, PRDATA=0.
- Reads have no side effects. Reading INTSTATUS does not clear it.

Input path, per pin i:
- Two-flop synchroniser: sync0, then sync1.
- Filter register filt[i].
- If DBEN[i]=0: filt <= sync1.
- If DBEN[i]=1, with cnt[i] a DEBOUNCE_W-bit counter:
  - sync1 == filt: cnt <= 0.
  - else if cnt == DBCNT: filt <= sync1, cnt <= 0.
  - else: cnt <= cnt+1.
- A glitch shorter than DBCNT+1 cycles is rejected.
- prev[i] <= filt[i] every cycle. It feeds edge detection.

Event type, by {INTTYPE1, INTTYPE0}:
- 00: level high, filt=1.
- 01: level low, filt=0.
- 10: rising edge, filt & ~prev.
- 11: falling edge, ~filt & prev.

INTSTATUS:
- Bit i is set on any cycle where INTEN[i] & event[i].
- Bit i is cleared by writing 1 to it at index 8.
- If set and clear hit the same bit in the same cycle, set wins.
- Clearing INTEN does not clear status. A level-type bit re-sets every cycle while the level persists.

Reset values:
- All registers, counters, sync/filt/prev flops: 0.
- interrupt = 0, PRDATA = 0 (index 0 with FUN0 = 0), PSLVERR = 0, PREADY = 1.
- Reset is asynchronous: outputs drop immediately, including mid-transfer.

## Timing
Take gpio_in stable and first sampled at edge N.
- sync1 = new value at N+1.
- filt = new value at N+2 with debounce off, or N+2+DBCNT with debounce on.
- INTSTATUS bit and interrupt high at N+3, or N+3+DBCNT.

Other latencies:
- Register write at access edge E: gpio_out, gpio_dir and gpio_mux change at E.
- W1C at E: interrupt falls at E, unless another status bit is still set or the event re-fires.

## Test plan
- Reset, then read all 14 indexes: all return 0. Indexes 14 and 15 return PSLVERR=1 and PRDATA=0.
- OUT=0x0000_00F0; OUTSET 0x3; OUTCLR 0x30; OUTTGL 0x101. Final OUT = 0x0000_01C2 and gpio_out matches. OUTSET, OUTCLR and OUTTGL read back 0.
- Pin 5 configured as rising edge with INTEN[5]=1; gpio_in[5] goes 0→1 at edge N. INTSTATUS = 0x20 and interrupt=1 at N+3. Reading INTSTATUS keeps it at 0x20. Writing 0x20 clears it and interrupt drops.
- Pin 0 at level high, held high, with W1C of bit 0 each cycle. The bit stays set (set wins). Drive the pin low, then W1C: cleared.
- DBEN[2]=1, DBCNT=4. A 3-cycle pulse on gpio_in[2]: PADIN[2] stays 0 and no interrupt. A pulse held for 10 cycles: PADIN[2]=1 at N+6.
- NUM_GPIO=8: write 0xFFFF_FFFF to DIR. Reads back 0x0000_00FF and gpio_dir = 0xFF. gpio_mux width is 16.
